// File: rtl/spi_controller_if.sv
// Bundle of the byte handshake and SPI pins between the spi_controller and its client.
// The master side is the client/target environment; the slave side is the controller.
interface spi_controller_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  last;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  valid;
  logic                  busy;
  logic                  cs_n;
  logic                  sck;
  logic                  sdo;
  logic                  sdi;
  logic                  stall;

  modport master (
    output start, tx_data, last, sdi, stall,
    input  ready, rx_data, valid, busy, cs_n, sck, sdo
  );

  modport slave (
    input  start, tx_data, last, sdi, stall,
    output ready, rx_data, valid, busy, cs_n, sck, sdo
  );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: shifts one byte per ready/start handshake, MSB first,
// checking the target's synchronized stall line before every byte.
module spi_controller #(
  parameter int unsigned SCK_DIV    = 2,
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  spi_controller_if.slave bus
);
  localparam int unsigned DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT_STALL,
    SHIFT_LO,
    SHIFT_HI,
    HOLD,
    CS_HIGH
  } state_t;

  state_t                state;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  last_q;
  logic                  stall_meta;
  logic                  stall_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      last_q      <= 1'b0;
      stall_meta  <= 1'b1;
      stall_sync  <= 1'b1;
      bus.cs_n    <= 1'b1;
      bus.sck     <= 1'b0;
      bus.sdo     <= 1'b0;
      bus.ready   <= 1'b1;
      bus.valid   <= 1'b0;
      bus.rx_data <= '0;
      bus.busy    <= 1'b0;
    end else begin
      // Synchronizer resets to "stalled" so nothing shifts before the target is seen idle.
      stall_meta <= bus.stall;
      stall_sync <= stall_meta;
      bus.valid  <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            shift     <= bus.tx_data;
            last_q    <= bus.last;
            bus.cs_n  <= 1'b0;
            bus.ready <= 1'b0;
            bus.busy  <= 1'b1;
            div_cnt   <= DIV_LAST;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (div_cnt == '0) state <= WAIT_STALL;
          else               div_cnt <= div_cnt - DIV_W'(1);
        end
        WAIT_STALL: begin
          if (!stall_sync) begin
            bit_cnt <= BIT_LAST;
            bus.sdo <= shift[DATA_WIDTH-1];
            div_cnt <= DIV_LAST;
            state   <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (div_cnt == '0) begin
            bus.sck <= 1'b1;
            shift   <= {shift[DATA_WIDTH-2:0], bus.sdi};
            div_cnt <= DIV_LAST;
            state   <= SHIFT_HI;
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        SHIFT_HI: begin
          if (div_cnt == '0) begin
            bus.sck <= 1'b0;
            div_cnt <= DIV_LAST;
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - BIT_W'(1);
              bus.sdo <= shift[DATA_WIDTH-1];
              state   <= SHIFT_LO;
            end else begin
              bus.rx_data <= shift;
              bus.valid   <= 1'b1;
              if (last_q) begin
                bus.cs_n <= 1'b1;
                state    <= CS_HIGH;
              end else begin
                bus.ready <= 1'b1;
                state     <= HOLD;
              end
            end
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        HOLD: begin
          if (bus.start) begin
            shift     <= bus.tx_data;
            last_q    <= bus.last;
            bus.ready <= 1'b0;
            state     <= WAIT_STALL;
          end
        end
        CS_HIGH: begin
          if (div_cnt == '0) begin
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
            state     <= IDLE;
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: loopback and scripted-target byte transfers,
// bursts, stall flow control, start spamming and mid-byte reset.
module tb_spi_controller;
  localparam int unsigned SCK_DIV = 2;
  localparam int unsigned DW      = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_controller_if #(.DATA_WIDTH(DW)) bus ();

  spi_controller #(.SCK_DIV(SCK_DIV), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];

  // Simple target: loopback, or a scripted byte shifted out MSB first on SCK falling edges.
  logic          loopback = 1'b1;
  logic [DW-1:0] tgt_byte = '0;
  logic [2:0]    tgt_idx  = '0;
  always @(negedge bus.sck or posedge bus.cs_n) begin
    if (bus.cs_n) tgt_idx <= '0;
    else          tgt_idx <= tgt_idx + 3'd1;
  end
  assign bus.sdi = loopback ? bus.sdo : tgt_byte[3'd7 - tgt_idx];

  int          sck_edges = 0;
  int          cs_rises  = 0;
  int          vcount    = 0;
  logic [DW-1:0] sdo_log = '0;
  always @(posedge bus.sck) begin
    sck_edges++;
    sdo_log <= {sdo_log[DW-2:0], bus.sdo};
  end
  always @(posedge bus.cs_n) cs_rises++;

  // Scoreboard: every valid pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      vcount++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_unexpected_valid got=%h expected=none", bus.rx_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (bus.rx_data !== e) begin
          failures++;
          $display("FAIL scoreboard_data got=%h expected=%h", bus.rx_data, e);
        end
      end
    end
  end

  task automatic send_byte(input logic [DW-1:0] d, input logic l, input logic [DW-1:0] e,
                           input logic push);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL send_wait_ready got=timeout expected=ready");
    end
    if (push) exp_q.push_back(e);
    bus.start   = 1'b1;
    bus.tx_data = d;
    bus.last    = l;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((bus.busy !== 1'b0 || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL wait_done got=timeout expected=idle");
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.cs_n, bus.sck, bus.sdo, bus.ready, bus.valid, bus.busy} !== 6'b100100) begin
      failures++;
      $display("FAIL reset_outputs got=%b expected=100100",
               {bus.cs_n, bus.sck, bus.sdo, bus.ready, bus.valid, bus.busy});
    end
    checks++;
    if (bus.rx_data !== '0) begin
      failures++;
      $display("FAIL reset_rx_data got=%h expected=00", bus.rx_data);
    end
  endtask

  task automatic test_loopback();
    int e0, v0, c0;
    e0 = sck_edges; v0 = vcount; c0 = cs_rises;
    loopback = 1'b1;
    send_byte(8'hA5, 1'b1, 8'hA5, 1'b1);
    wait_done();
    checks++;
    if (sck_edges - e0 != 8) begin
      failures++;
      $display("FAIL loopback_sck_edges got=%0d expected=8", sck_edges - e0);
    end
    checks++;
    if (sdo_log !== 8'hA5) begin
      failures++;
      $display("FAIL loopback_sdo_bits got=%h expected=a5", sdo_log);
    end
    checks++;
    if (vcount - v0 != 1 || cs_rises - c0 != 1 || bus.cs_n !== 1'b1) begin
      failures++;
      $display("FAIL loopback_framing got=valids:%0d cs_rises:%0d cs_n:%b expected=1,1,1",
               vcount - v0, cs_rises - c0, bus.cs_n);
    end
  endtask

  task automatic test_burst();
    int e0, v0, c0;
    e0 = sck_edges; v0 = vcount; c0 = cs_rises;
    send_byte(8'h01, 1'b0, 8'h01, 1'b1);
    send_byte(8'h02, 1'b0, 8'h02, 1'b1);
    checks++;
    if (cs_rises != c0) begin
      failures++;
      $display("FAIL burst_cs_mid got=%0d expected=%0d", cs_rises, c0);
    end
    send_byte(8'h03, 1'b1, 8'h03, 1'b1);
    wait_done();
    checks++;
    if (sck_edges - e0 != 24 || vcount - v0 != 3 || cs_rises - c0 != 1) begin
      failures++;
      $display("FAIL burst_counts got=edges:%0d valids:%0d cs_rises:%0d expected=24,3,1",
               sck_edges - e0, vcount - v0, cs_rises - c0);
    end
  endtask

  task automatic test_stall();
    int e0, n;
    send_byte(8'h5C, 1'b0, 8'h5C, 1'b1);
    while (bus.ready !== 1'b1) @(negedge clk);
    bus.stall = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'hC7, 1'b1, 8'hC7, 1'b1);
    e0 = sck_edges;
    repeat (50) @(negedge clk);
    checks++;
    if (sck_edges != e0 || bus.cs_n !== 1'b0) begin
      failures++;
      $display("FAIL stall_hold got=edges:%0d cs_n:%b expected=0,0", sck_edges - e0, bus.cs_n);
    end
    bus.stall = 1'b0;
    n = 0;
    while (bus.sck !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n < 3 || n > SCK_DIV + 3) begin
      failures++;
      $display("FAIL stall_release_latency got=%0d expected=3..%0d", n, SCK_DIV + 3);
    end
    wait_done();
  endtask

  task automatic test_target();
    int e0;
    e0 = sck_edges;
    loopback = 1'b0;
    tgt_byte = 8'h3C;
    send_byte(8'hFF, 1'b1, 8'h3C, 1'b1);
    wait_done();
    checks++;
    if (sdo_log !== 8'hFF || sck_edges - e0 != 8) begin
      failures++;
      $display("FAIL target_sdo got=%h edges:%0d expected=ff,8", sdo_log, sck_edges - e0);
    end
    checks++;
    if (bus.rx_data !== 8'h3C) begin
      failures++;
      $display("FAIL target_rx_data got=%h expected=3c", bus.rx_data);
    end
    loopback = 1'b1;
  endtask

  task automatic test_start_spam();
    int e0, v0, n;
    e0 = sck_edges; v0 = vcount;
    @(negedge clk);
    exp_q.push_back(8'h5A);
    bus.start   = 1'b1;
    bus.tx_data = 8'h5A;
    bus.last    = 1'b1;
    n = 0;
    while (bus.valid !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    wait_done();
    checks++;
    if (vcount - v0 != 1 || sck_edges - e0 != 8) begin
      failures++;
      $display("FAIL start_spam got=valids:%0d edges:%0d expected=1,8", vcount - v0,
               sck_edges - e0);
    end
  endtask

  task automatic test_reset_mid();
    int e0, v0, n;
    e0 = sck_edges; v0 = vcount;
    send_byte(8'hC3, 1'b1, 8'h00, 1'b0);
    n = 0;
    while (sck_edges - e0 < 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.cs_n, bus.sck, bus.ready, bus.busy} !== 4'b1010) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%b expected=1010",
               {bus.cs_n, bus.sck, bus.ready, bus.busy});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (vcount != v0) begin
      failures++;
      $display("FAIL reset_mid_no_valid got=%0d expected=0", vcount - v0);
    end
    send_byte(8'h96, 1'b1, 8'h96, 1'b1);
    wait_done();
    checks++;
    if (bus.rx_data !== 8'h96 || bus.cs_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_recover got=%h cs_n:%b expected=96,1", bus.rx_data, bus.cs_n);
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.tx_data = '0;
    bus.last    = 1'b0;
    bus.stall   = 1'b0;
    test_reset();
    test_loopback();
    test_burst();
    test_stall();
    test_target();
    test_start_spam();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
